// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, opcode width and sequencer FSM states.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_COMPLEMENT = 4'd0;
    localparam logic [OP_W-1:0] OP_AND        = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR        = 4'd2;
    localparam logic [OP_W-1:0] OP_OR         = 4'd3;
    localparam logic [OP_W-1:0] OP_DECREMENT  = 4'd4;
    localparam logic [OP_W-1:0] OP_ADD        = 4'd5;
    localparam logic [OP_W-1:0] OP_SUB        = 4'd6;
    localparam logic [OP_W-1:0] OP_INCREMENT  = 4'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_t;

    // Only opcodes 0..7 exist; the top bit marks an illegal request.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return !op[OP_W-1];
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by alu_seq_ctrl; arithmetic wraps modulo 2**DATA_W.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] alu_op1,
    input  logic [DATA_W-1:0] alu_op2,
    input  logic [OP_W-1:0]   alu_control,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] w_result;

    always_comb begin
        w_result = '0;
        case (alu_control)
            OP_COMPLEMENT: w_result = ~alu_op1;
            OP_AND:        w_result = alu_op1 & alu_op2;
            OP_XOR:        w_result = alu_op1 ^ alu_op2;
            OP_OR:         w_result = alu_op1 | alu_op2;
            OP_DECREMENT:  w_result = alu_op1 - ONE;
            OP_ADD:        w_result = alu_op1 + alu_op2;
            OP_SUB:        w_result = alu_op1 - alu_op2;
            OP_INCREMENT:  w_result = alu_op1 + ONE;
            default:       w_result = '0;
        endcase
    end

    assign alu_result = w_result;
    assign alu_zero   = (w_result == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Iterating ALU initiator: takes one command, feeds alu_result back as op1 for
// cmd_rpt+1 iterations (optionally stopping on zero), then returns the result.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RPT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [RPT_W-1:0]  cmd_rpt,
    input  logic              cmd_stop_zero,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [RPT_W:0]    rsp_iters,
    output logic              rsp_illegal
);

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_op2;
    logic [OP_W-1:0]   r_op;
    logic [RPT_W:0]    r_limit;
    logic [RPT_W:0]    r_iter;
    logic              r_stop;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
    logic [RPT_W:0]    r_rsp_iters;
    logic              r_rsp_illegal;

    logic [RPT_W:0]    w_iter_nxt;
    logic              w_last;

    assign w_iter_nxt = r_iter + 1'b1;
    assign w_last     = (w_iter_nxt == r_limit) || (r_stop && alu_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_acc         <= '0;
            r_op2         <= '0;
            r_op          <= '0;
            r_limit       <= '0;
            r_iter        <= '0;
            r_stop        <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_iters   <= '0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (cmd_valid) begin
                        r_acc       <= cmd_a;
                        r_op2       <= cmd_b;
                        r_op        <= cmd_op;
                        r_limit     <= {1'b0, cmd_rpt} + 1'b1;
                        r_stop      <= cmd_stop_zero;
                        r_iter      <= '0;
                        r_cmd_ready <= 1'b0;
                        if (op_is_legal(cmd_op)) begin
                            r_state <= StExec;
                        end else begin
                            // Illegal opcodes never touch the ALU.
                            r_rsp_result  <= '0;
                            r_rsp_zero    <= 1'b1;
                            r_rsp_iters   <= '0;
                            r_rsp_illegal <= 1'b1;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= StDone;
                        end
                    end
                end
                StExec: begin
                    r_acc  <= alu_result;
                    r_iter <= w_iter_nxt;
                    if (w_last) begin
                        r_rsp_result  <= alu_result;
                        r_rsp_zero    <= alu_zero;
                        r_rsp_iters   <= w_iter_nxt;
                        r_rsp_illegal <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= StDone;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign alu_op1     = r_acc;
    assign alu_op2     = r_op2;
    assign alu_control = r_op;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_iters   = r_rsp_iters;
    assign rsp_illegal = r_rsp_illegal;

endmodule
